// File: rtl/rom_fetch_unit_if.sv
// rom_fetch_unit_if: groups the two buses of the ROM fetch unit.
//   ROM side      : rom_address (to ROM.address), rom_q (from ROM.q)
//   Downstream    : instr, instr_addr, instr_valid (to consumer), instr_ready (from consumer)
// modport master is the fetch unit; modport slave is the ROM + consumer side.
interface rom_fetch_unit_if;
  logic [7:0]  rom_address;
  logic [31:0] rom_q;
  logic [31:0] instr;
  logic [7:0]  instr_addr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output rom_address,
    input  rom_q,
    output instr,
    output instr_addr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  rom_address,
    output rom_q,
    input  instr,
    input  instr_addr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: sequencer in front of a 256x32 synchronous-read instruction ROM.
// Issues addresses from an 8-bit PC, tracks in-flight reads through a
// ROM_LATENCY-deep {valid, addr} pipe, buffers returned words in a FIFO and
// hands them downstream on a valid/ready handshake. Supports start, jump with
// flush, PC wrap-around and halting when HALT_WORD is transferred out.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   start          1-cycle pulse, begins fetching at address 0 from IDLE
//   jump_en/addr   redirect: flush everything and restart fetching at jump_addr
//   halted         high while in HALT
//   bus (master)   ROM address/data and downstream instr handshake
module rom_fetch_unit #(
  parameter int          ROM_LATENCY = 1,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             jump_en,
  input  logic [7:0]       jump_addr,
  output logic             halted,
  rom_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t                 state, next_state;
  logic [7:0]             pc;
  logic [ROM_LATENCY-1:0] pipe_valid;
  logic [7:0]             pipe_addr [ROM_LATENCY];
  logic [31:0]            fifo_data [FIFO_DEPTH];
  logic [7:0]             fifo_tag  [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       fifo_count;
  logic [SUM_W-1:0]       inflight_count;
  logic                   credit_ok, issue, push, pop, halt_hit, flush;

  assign bus.rom_address = pc;
  assign bus.instr_valid = (fifo_count != '0);
  // Gate the head with valid so the outputs read zero while the FIFO is empty.
  assign bus.instr       = bus.instr_valid ? fifo_data[rd_ptr] : '0;
  assign bus.instr_addr  = bus.instr_valid ? fifo_tag[rd_ptr]  : '0;
  assign halted          = (state == HALT);

  assign pop      = bus.instr_valid && bus.instr_ready;
  assign halt_hit = pop && (fifo_data[rd_ptr] == HALT_WORD);
  assign flush    = jump_en || halt_hit;
  // Returns that land in a flush cycle belong to the abandoned stream.
  assign push     = pipe_valid[ROM_LATENCY-1] && !flush;

  // Credit counts every slot already promised (buffered + in flight) and
  // deliberately ignores a same-cycle pop, so the FIFO can never overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    inflight_count = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight_count = inflight_count + SUM_W'(pipe_valid[i]);
    end
  end

  assign credit_ok = (SUM_W'(fifo_count) + inflight_count) < SUM_W'(FIFO_DEPTH);
  assign issue     = (state == FETCH) && credit_ok;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)    next_state = FETCH;
      FETCH:   if (halt_hit) next_state = HALT;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
    // A redirect overrides everything, including start and a halt transfer.
    if (jump_en) next_state = FETCH;
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       pc <= '0;
    else if (jump_en)                pc <= jump_addr;
    else if (state == IDLE && start) pc <= '0;
    else if (issue)                  pc <= pc + 8'd1; // 8'hFF wraps to 8'h00
  end

  // Valid bits of the return pipe: a word appears on rom_q ROM_LATENCY cycles
  // after its address was issued, exactly when its entry leaves this pipe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
    end else if (flush) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= issue;
      for (int i = 1; i < ROM_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  // Address tags are qualified by pipe_valid, so they need no reset.
  always_ff @(posedge clock) begin
    pipe_addr[0] <= pc;
    for (int i = 1; i < ROM_LATENCY; i++) pipe_addr[i] <= pipe_addr[i-1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the FIFO storage is not reset; fifo_count marks which entries are meaningful.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.rom_q;
      fifo_tag[wr_ptr]  <= pipe_addr[ROM_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
`timescale 1ns/1ps
module tb_rom_fetch_unit;
  localparam int          ROM_LATENCY = 1;
  localparam int          FIFO_DEPTH  = 4;
  localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;

  logic       clock;
  logic       reset;
  logic       start;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       halted;

  rom_fetch_unit_if bus ();

  logic [31:0] rom_mem [256];
  logic [7:0]  exp_addr;
  int          tests = 0;
  int          fails = 0;

  rom_fetch_unit #(
    .ROM_LATENCY (ROM_LATENCY),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .HALT_WORD   (HALT_WORD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .halted    (halted),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read ROM, latency 1.
  always @(posedge clock) bus.rom_q <= rom_mem[bus.rom_address];

  // Push into a full FIFO without a pop would be an overflow.
  always @(negedge clock) begin
    if (reset === 1'b0 && dut.push && !dut.pop && int'(dut.fifo_count) == FIFO_DEPTH) begin
      fails++;
      $display("FAIL fifo_overflow: push with count %0d, limit %0d", dut.fifo_count, FIFO_DEPTH);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk_word(input string name, input logic [31:0] want_word, input logic [7:0] want_addr);
    // checks the delivered head against bench-computed values
    tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== want_word || bus.instr_addr !== want_addr) begin
      fails++;
      $display("FAIL %s: got valid=%b instr=%h addr=%h, expected valid=1 instr=%h addr=%h",
               name, bus.instr_valid, bus.instr, bus.instr_addr, want_word, want_addr);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic chk_byte(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; jump_en = 1'b0; jump_addr = 8'h00;
    bus.instr_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk_bit("reset_valid", bus.instr_valid, 1'b0);
    tests++;
    if (bus.instr !== 32'h0) begin
      fails++; $display("FAIL reset_instr: got %h expected 00000000", bus.instr);
    end
    chk_byte("reset_instr_addr", bus.instr_addr, 8'h00);
    chk_bit("reset_halted", halted, 1'b0);
    chk_byte("reset_rom_address", bus.rom_address, 8'h00);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk_bit("idle_no_valid", bus.instr_valid, 1'b0);
    chk_byte("idle_pc_holds", bus.rom_address, 8'h00);
  endtask

  task automatic test_stream();
    bus.instr_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);            // cycle s+1
    start = 1'b0;
    chk_bit("stream_valid_s1", bus.instr_valid, 1'b0);
    @(negedge clock);            // cycle s+2
    chk_bit("stream_valid_s2", bus.instr_valid, 1'b0);
    @(negedge clock);            // cycle s+3: first word
    exp_addr = 8'h00;
    for (int k = 0; k < 12; k++) begin
      // start pulse in FETCH must be ignored
      start = (k == 4);
      chk_word("stream_word", {24'h0, exp_addr}, exp_addr);
      exp_addr = exp_addr + 8'd1;
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic test_backpressure();
    // head shows exp_addr; stall it for 10 cycles
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk_word("bp_hold", {24'h0, exp_addr}, exp_addr);
    end
    // credit limit: exactly FIFO_DEPTH words fetched beyond the stalled head
    chk_byte("bp_pc_limit", bus.rom_address, exp_addr + 8'd4);
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk_word("bp_resume", {24'h0, exp_addr}, exp_addr);
      exp_addr = exp_addr + 8'd1;
      @(negedge clock);
    end
  endtask

  task automatic test_jump();
    bus.instr_ready = 1'b0;
    repeat (2) @(negedge clock);  // 3 words queued, 1 in flight
    chk_bit("jump_pre_queued", bus.instr_valid, 1'b1);
    jump_en = 1'b1; jump_addr = 8'h80;
    @(negedge clock);             // cycle j+1
    jump_en = 1'b0;
    bus.instr_ready = 1'b1;
    chk_bit("jump_flush_valid", bus.instr_valid, 1'b0);
    chk_byte("jump_rom_address", bus.rom_address, 8'h80);
    @(negedge clock);             // cycle j+2
    chk_bit("jump_valid_j2", bus.instr_valid, 1'b0);
    @(negedge clock);             // cycle j+3
    exp_addr = 8'h80;
    for (int k = 0; k < 4; k++) begin
      chk_word("jump_word", {24'h0, exp_addr}, exp_addr);
      exp_addr = exp_addr + 8'd1;
      @(negedge clock);
    end
  endtask

  task automatic test_wrap();
    jump_en = 1'b1; jump_addr = 8'hFE;
    @(negedge clock);
    jump_en = 1'b0;
    chk_bit("wrap_flush_valid", bus.instr_valid, 1'b0);
    chk_byte("wrap_rom_address", bus.rom_address, 8'hFE);
    repeat (2) @(negedge clock);
    exp_addr = 8'hFE;
    for (int k = 0; k < 4; k++) begin   // FE, FF, 00, 01
      chk_word("wrap_word", {24'h0, exp_addr}, exp_addr);
      exp_addr = exp_addr + 8'd1;
      @(negedge clock);
    end
  endtask

  task automatic test_halt();
    rom_mem[5] = HALT_WORD;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);        // cycle s+3
    for (int a = 0; a < 6; a++) begin
      exp_addr = 8'(a);
      chk_word("halt_stream", (a == 5) ? HALT_WORD : {24'h0, exp_addr}, exp_addr);
      @(negedge clock);
    end
    // issue ran every cycle up to the halt transfer, last issued address 7
    chk_bit("halt_halted", halted, 1'b1);
    chk_bit("halt_valid", bus.instr_valid, 1'b0);
    chk_byte("halt_rom_address", bus.rom_address, 8'h08);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      tests++;
      if (bus.instr_valid !== 1'b0 || bus.rom_address !== 8'h08 || halted !== 1'b1) begin
        fails++;
        $display("FAIL halt_frozen: got valid=%b rom_address=%h halted=%b expected 0/08/1",
                 bus.instr_valid, bus.rom_address, halted);
      end
    end
    jump_en = 1'b1; jump_addr = 8'h10;
    @(negedge clock);
    jump_en = 1'b0;
    chk_bit("halt_jump_halted", halted, 1'b0);
    chk_byte("halt_jump_rom_address", bus.rom_address, 8'h10);
    repeat (2) @(negedge clock);
    exp_addr = 8'h10;
    for (int k = 0; k < 3; k++) begin
      chk_word("halt_resume", {24'h0, exp_addr}, exp_addr);
      exp_addr = exp_addr + 8'd1;
      @(negedge clock);
    end
    rom_mem[5] = 32'h0000_0005;
  endtask

  task automatic test_reset_mid();
    chk_bit("rst_mid_pre_valid", bus.instr_valid, 1'b1);
    reset = 1'b1;
    #1;
    tests++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || bus.instr_addr !== 8'h00 ||
        halted !== 1'b0 || bus.rom_address !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_outputs: got valid=%b instr=%h addr=%h halted=%b rom_address=%h expected all zero",
               bus.instr_valid, bus.instr, bus.instr_addr, halted, bus.rom_address);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      tests++;
      if (bus.instr_valid !== 1'b0 || bus.rom_address !== 8'h00) begin
        fails++;
        $display("FAIL rst_mid_idle: got valid=%b rom_address=%h expected 0/00",
                 bus.instr_valid, bus.rom_address);
      end
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    chk_word("rst_mid_restart", 32'h0000_0000, 8'h00);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom_mem[a] = {24'h0, 8'(a)};
    bus.rom_q = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rom_fetch_unit.md
Name: rom_fetch_unit

Overview:
- Sequencer directly upstream of the 256x32 instruction ROM (8-bit address, 32-bit q, synchronous read).
- Drives the ROM address stream and absorbs the ROM read latency.
- Buffers returned words in a small FIFO and presents them downstream on a valid/ready handshake.
- Supports start, jump/redirect with flush, 8-bit PC wrap-around, and halt on a sentinel word.

Parameters:
- ROM_LATENCY, 1: cycles from ROM address sample edge to q valid. Legal range 1..3.
- FIFO_DEPTH, 4: output buffer entries. Power of two, must be >= ROM_LATENCY+2 for full throughput.
- HALT_WORD, 32'hFFFF_FFFF: accepting this word stops fetching.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  1-cycle pulse; begins fetching from address 0 when IDLE.
- jump_en  in  1  redirect request, sampled each rising edge.
- jump_addr  in  8  redirect target.
- rom_address  out  8  address to ROM.address; equals the PC register.
- rom_q  in  32  ROM.q.
- instr  out  32  word at FIFO head.
- instr_addr  out  8  ROM address the instr word came from.
- instr_valid  out  1  FIFO non-empty.
- instr_ready  in  1  downstream accepts; transfer occurs when instr_valid && instr_ready.
- halted  out  1  high in HALT state.

Behaviour:
Reset
- Async assert: pc=0, rom_address=0, state=IDLE, FIFO empty, in-flight pipe cleared.
- Outputs: instr=0, instr_addr=0, instr_valid=0, halted=0.

States
- IDLE -> FETCH on start.
- FETCH -> HALT when HALT_WORD is transferred out.
- HALT -> FETCH on jump_en.
- Any state -> FETCH on jump_en.
- start is ignored outside IDLE.

Issue
- In FETCH, a request is issued in cycle c iff fifo_count + inflight_count < FIFO_DEPTH.
- The credit check is conservative: it ignores any same-cycle pop.
- On issue, pc increments at the end of cycle c. 8'hFF wraps to 8'h00, no flag.
- No issue occurs in IDLE or HALT; pc holds.

Return path
- Each issue enters a ROM_LATENCY-deep shift pipe of {valid, addr}.
- Word for address A issued in cycle c appears on rom_q in cycle c+ROM_LATENCY.
- It is written to the FIFO at the end of that cycle with tag A.
- Timing from start sampled at edge s: first issue in cycle s+1; instr_valid first high in cycle s+ROM_LATENCY+2.
- Sustained throughput is 1 word/cycle while instr_ready=1.

Handshake
- instr and instr_addr are stable while instr_valid && !instr_ready.
- FIFO push and pop may occur in the same cycle; count is unchanged.
- The FIFO never overflows. An overflow is a design bug; the bench asserts on it.

Jump (jump_en sampled at edge j)
- FIFO and in-flight pipe are flushed; late ROM returns from before the jump are discarded.
- pc = jump_addr; state = FETCH; halted = 0.
- instr_valid=0 in cycle j+1, and rom_address=jump_addr in cycle j+1.
- A transfer in cycle j still completes. Jump wins over a same-cycle HALT_WORD transfer: the unit stays in FETCH.
- jump_en together with start in IDLE: jump wins.

Halt
- On transfer of HALT_WORD: issuing stops the next cycle.
- The remaining FIFO entries and in-flight words are flushed.
- halted=1 and instr_valid=0 from the next cycle.

Reset mid-operation
- Immediate return to the reset state; nothing is delivered afterwards.

Test Plan:
- Stream: ROM[a]={24'h0,a}, start, instr_ready=1 -> instr 0,1,2,... on consecutive cycles; first instr_valid at s+3 (LAT=1); instr_addr matches the low byte of the word.
- Backpressure: instr_ready=0 for 10 cycles mid-stream -> at most FIFO_DEPTH words buffered, instr held stable, no loss or duplicates, stream resumes in order.
- Jump: jump_en with jump_addr=8'h80 while 3 words are queued -> queued and in-flight words dropped, next delivered word is 8'h80 with instr_addr=8'h80.
- Wrap: jump to 8'hFE -> delivered addresses FE, FF, 00, 01.
- Halt: ROM[5]=HALT_WORD -> words 0..5 delivered, then halted=1, instr_valid stays 0, rom_address frozen; jump to 8'h10 resumes at 10.
- Reset mid-stream with instr_valid=1 -> all outputs at reset values immediately, no delivery until the next start.
